// File: rtl/click_pipe.sv
// Two-phase bundled-data elastic pipeline: a linear chain of DEPTH click stages.
// Every stage is self-timed and clocks its phase and data registers on its own click pulse.

module click_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic                  TOKEN_INIT = 1'b0,
  parameter logic [DATA_WIDTH-1:0] DATA_INIT  = '0
) (
  input  logic                  reset,
  input  logic                  req_in,
  input  logic                  ack_in,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic                  phase_in,
  output logic                  phase_out,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  occ
);
  logic click;

  // Held low during reset so a stage already enabled by preloaded neighbours
  // gets a real rising edge on release; otherwise its token could never move.
  assign click = ~reset & (req_in ^ phase_in) & ~(ack_in ^ phase_out);

  always_ff @(posedge click or posedge reset) begin
    if (reset) begin
      phase_in  <= 1'b0;
      phase_out <= TOKEN_INIT;
      data      <= DATA_INIT;
    end else begin
      phase_in  <= ~phase_in;
      phase_out <= ~phase_out;
      data      <= d_in;
    end
  end

  assign occ = phase_out ^ ack_in;
endmodule

module click_pipe #(
  parameter int                              DATA_WIDTH = 32,
  parameter int                              DEPTH      = 4,
  parameter logic [DEPTH-1:0]                TOKEN_MASK = '0,
  parameter logic [DEPTH*DATA_WIDTH-1:0]     INIT_DATA  = '0,
  parameter int                              REQ_DELAY  = 0
) (
  input  logic                  reset,
  input  logic                  in_req,
  output logic                  in_ack,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_req,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ack,
  output logic [DEPTH-1:0]      occ
);
  // Matched delays are zero in this netlist; REQ_DELAY is only range-checked.
  if (DEPTH < 1 || DEPTH > 16 || REQ_DELAY < 0) begin : g_bad_param
    $error("click_pipe: DEPTH must be 1..16 and REQ_DELAY >= 0");
  end

  // Handshake chain: req_c[i] feeds stage i, ack_c[i+1] acknowledges it.
  logic [DEPTH:0]                 req_c;
  logic [DEPTH:0]                 ack_c;
  logic [DEPTH:0][DATA_WIDTH-1:0] dat_c;

  assign req_c[0]     = in_req;
  assign ack_c[DEPTH] = out_ack;
  assign dat_c[0]     = in_data;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    click_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .TOKEN_INIT (TOKEN_MASK[i]),
      .DATA_INIT  (INIT_DATA[i*DATA_WIDTH +: DATA_WIDTH])
    ) u_stage (
      .reset     (reset),
      .req_in    (req_c[i]),
      .ack_in    (ack_c[i+1]),
      .d_in      (dat_c[i]),
      .phase_in  (ack_c[i]),
      .phase_out (req_c[i+1]),
      .data      (dat_c[i+1]),
      .occ       (occ[i])
    );
  end

  assign in_ack   = ack_c[0];
  assign out_req  = req_c[DEPTH];
  assign out_data = dat_c[DEPTH];
endmodule
